// File: rtl/reg_bank.sv
// Register bank for a small accumulator CPU: eight 12-bit registers loaded from the
// shared bus, PC/AC/R1 increment and AC clear, a data-memory write strobe and a write status.
module reg_bank #(
  parameter int N = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] busin,
  input  logic         wr_valid,
  input  logic [3:0]   write_en,
  input  logic [3:0]   inc_en,
  output logic [11:0]  r1,
  output logic [11:0]  r2,
  output logic [11:0]  r3,
  output logic [11:0]  r4,
  output logic [11:0]  ir,
  output logic [11:0]  ac,
  output logic [11:0]  ar,
  output logic [11:0]  pc,
  output logic         dm_we,
  output logic [11:0]  dm_wdata,
  output logic         wr_done,
  output logic         wr_err
);

  // Handshake: wr_valid has no ready partner; the bank always accepts, so every edge
  // with wr_valid=1 is one write transaction, reported one cycle later on wr_done/wr_err.

  localparam logic [3:0] CODE_FIRST = 4'd4;
  localparam logic [3:0] CODE_LAST  = 4'd12;

  // One-hot destination: bit 0 = IR (code 4) ... bit 8 = DM (code 12).
  localparam int SEL_IR = 0;
  localparam int SEL_AC = 1;
  localparam int SEL_AR = 2;
  localparam int SEL_R1 = 3;
  localparam int SEL_R2 = 4;
  localparam int SEL_R3 = 5;
  localparam int SEL_R4 = 6;
  localparam int SEL_PC = 7;
  localparam int SEL_DM = 8;

  logic [11:0] wdata;
  logic        mapped;
  logic        accept;
  logic        reject;
  logic [8:0]  sel;

  assign wdata = busin[11:0];

  // Upper bus bits are deliberately dropped on every write.
  if (N > 12) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^busin[N-1:12];
  end

  always_comb begin
    sel    = '0;
    mapped = (write_en >= CODE_FIRST) && (write_en <= CODE_LAST);
    accept = wr_valid && mapped;
    reject = wr_valid && !mapped;
    if (accept) begin
      sel = 9'd1 << (write_en - CODE_FIRST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      ac       <= '0;
      ar       <= '0;
      r1       <= '0;
      r2       <= '0;
      r3       <= '0;
      r4       <= '0;
      pc       <= '0;
      dm_we    <= 1'b0;
      dm_wdata <= '0;
      wr_done  <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      if (sel[SEL_IR]) ir <= wdata;
      if (sel[SEL_AR]) ar <= wdata;
      if (sel[SEL_R2]) r2 <= wdata;
      if (sel[SEL_R3]) r3 <= wdata;
      if (sel[SEL_R4]) r4 <= wdata;

      // Write beats clear, clear beats increment.
      if (sel[SEL_AC])     ac <= wdata;
      else if (inc_en[3])  ac <= '0;
      else if (inc_en[1])  ac <= ac + 12'd1;

      if (sel[SEL_PC])     pc <= wdata;
      else if (inc_en[0])  pc <= pc + 12'd1;

      if (sel[SEL_R1])     r1 <= wdata;
      else if (inc_en[2])  r1 <= r1 + 12'd1;

      dm_we <= sel[SEL_DM];
      if (sel[SEL_DM]) dm_wdata <= wdata;

      wr_done <= accept;
      wr_err  <= reject;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed corner cases then random traffic,
// checked each cycle against a register-array reference model.
module tb_reg_bank;

  localparam int N = 17;
  localparam int W = 8 * 12 + 1 + 12 + 1 + 1;

  // Model register index = write code - 4.
  localparam int IX_IR = 0;
  localparam int IX_AC = 1;
  localparam int IX_R1 = 3;
  localparam int IX_PC = 7;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] busin;
  logic         wr_valid;
  logic [3:0]   write_en;
  logic [3:0]   inc_en;
  logic [11:0]  r1, r2, r3, r4, ir, ac, ar, pc;
  logic         dm_we;
  logic [11:0]  dm_wdata;
  logic         wr_done;
  logic         wr_err;

  reg_bank #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .busin    (busin),
    .wr_valid (wr_valid),
    .write_en (write_en),
    .inc_en   (inc_en),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
    .r4       (r4),
    .ir       (ir),
    .ac       (ac),
    .ar       (ar),
    .pc       (pc),
    .dm_we    (dm_we),
    .dm_wdata (dm_wdata),
    .wr_done  (wr_done),
    .wr_err   (wr_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] obs;
  assign obs = {ir, ac, ar, r1, r2, r3, r4, pc, dm_we, dm_wdata, wr_done, wr_err};

  // Reference model
  logic [11:0] m_reg [8];
  logic        m_dm_we;
  logic [11:0] m_dm_wdata;
  logic        m_done;
  logic        m_err;

  logic [W-1:0] exp_q [$];
  int total;
  int bad;

  function automatic logic [11:0] wrap_inc(input logic [11:0] v);
    int t;
    t = (int'(v) + 1) % 4096;
    return t[11:0];
  endfunction

  function automatic logic [W-1:0] model_vec();
    return {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4], m_reg[5], m_reg[6], m_reg[7],
            m_dm_we, m_dm_wdata, m_done, m_err};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 12'd0;
    m_dm_we    = 1'b0;
    m_dm_wdata = 12'd0;
    m_done     = 1'b0;
    m_err      = 1'b0;
  endtask

  task automatic model_step(input logic wv, input logic [3:0] we, input logic [3:0] inc,
                            input logic [N-1:0] bus);
    logic [11:0] nxt [8];
    int code;
    for (int i = 0; i < 8; i++) nxt[i] = m_reg[i];
    if (inc[0]) nxt[IX_PC] = wrap_inc(m_reg[IX_PC]);
    if (inc[1]) nxt[IX_AC] = wrap_inc(m_reg[IX_AC]);
    if (inc[3]) nxt[IX_AC] = 12'd0;
    if (inc[2]) nxt[IX_R1] = wrap_inc(m_reg[IX_R1]);
    m_dm_we = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    code    = int'(we);
    if (wv) begin
      if (code >= 4 && code <= 11) begin
        nxt[code - 4] = bus[11:0];
        m_done = 1'b1;
      end else if (code == 12) begin
        m_dm_we    = 1'b1;
        m_dm_wdata = bus[11:0];
        m_done     = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    for (int i = 0; i < 8; i++) m_reg[i] = nxt[i];
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Driver: called #1 after a rising edge; applies inputs for the next edge and checks after it.
  task automatic drive(input string tag, input logic wv, input logic [3:0] we,
                       input logic [3:0] inc, input logic [N-1:0] bus);
    logic [W-1:0] e;
    wr_valid = wv;
    write_en = we;
    inc_en   = inc;
    busin    = bus;
    model_step(wv, we, inc, bus);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, obs, e);
  endtask

  task automatic idle(input string tag);
    drive(tag, 1'b0, 4'd0, 4'd0, '0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    write_en = 4'd0;
    inc_en   = 4'd0;
    busin    = '0;
    model_reset();

    #12;
    check("reset_init", obs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First write after reset, then every register code once (back-to-back accepts).
    drive("first_wr_ir", 1'b1, 4'd4, 4'd0, 17'h00123);
    for (int c = 4; c <= 11; c++) begin
      drive("b2b_wr", 1'b1, 4'(c), 4'd0, N'($urandom));
      check("b2b_done", N'(wr_done), N'(1));
    end

    // Truncation of upper bus bits
    drive("trunc", 1'b1, 4'd7, 4'd0, 17'h1ABCD);
    check("trunc_r1", W'(r1), W'(12'hBCD));
    check("trunc_done", W'(wr_done), W'(1'b1));
    idle("trunc_idle");
    check("trunc_done_drop", W'(wr_done), W'(1'b0));

    // Modulo-4096 wrap and clear-over-increment
    drive("pc_load", 1'b1, 4'd11, 4'd0, 17'h00FFF);
    drive("pc_wrap", 1'b0, 4'd0, 4'b0001, '0);
    check("pc_wrap_val", W'(pc), W'(12'h000));
    drive("ac_load5", 1'b1, 4'd5, 4'd0, 17'h00005);
    drive("ac_clr_inc", 1'b0, 4'd0, 4'b1010, '0);
    check("ac_clr_val", W'(ac), W'(12'h000));
    drive("r1_load", 1'b1, 4'd7, 4'd0, 17'h00FFF);
    drive("r1_wrap", 1'b0, 4'd0, 4'b0100, '0);
    check("r1_wrap_val", W'(r1), W'(12'h000));

    // Write beats increment on the same register
    drive("ac_load3", 1'b1, 4'd5, 4'd0, 17'h00003);
    drive("ac_prio", 1'b1, 4'd5, 4'b0010, 17'h00010);
    check("ac_prio_val", W'(ac), W'(12'h010));
    drive("pc_prio", 1'b1, 4'd11, 4'b0001, 17'h00ABC);
    check("pc_prio_val", W'(pc), W'(12'hABC));

    // Independent registers updated together
    drive("r2_and_pcinc", 1'b1, 4'd8, 4'b0101, 17'h00456);

    // Data-memory path
    drive("dm_wr", 1'b1, 4'd12, 4'd0, 17'h00777);
    check("dm_we_hi", W'(dm_we), W'(1'b1));
    check("dm_wdata", W'(dm_wdata), W'(12'h777));
    idle("dm_idle");
    check("dm_we_lo", W'(dm_we), W'(1'b0));
    check("dm_wdata_hold", W'(dm_wdata), W'(12'h777));

    // Unmapped codes
    drive("err_14", 1'b1, 4'd14, 4'd0, 17'h00321);
    check("err_pulse", W'({wr_err, wr_done}), W'(2'b10));
    for (int c = 0; c < 4; c++) drive("err_low", 1'b1, 4'(c), 4'd0, N'($urandom));
    drive("err_13", 1'b1, 4'd13, 4'd0, N'($urandom));
    drive("err_15", 1'b1, 4'd15, 4'd0, N'($urandom));
    idle("err_idle");

    // Unqualified codes do nothing
    drive("no_valid", 1'b0, 4'd6, 4'd0, 17'h00999);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive("rand", ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), N'($urandom));
    end

    // Asynchronous reset mid-pulse cancels dm_we/wr_done
    for (int c = 4; c <= 11; c++) drive("preload", 1'b1, 4'(c), 4'd0, 17'h00F0F);
    drive("pre_rst_dm", 1'b1, 4'd12, 4'd0, 17'h00ABC);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", obs, '0);
    wr_valid = 1'b0;
    @(negedge clk);
    check("reset_hold", obs, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive("post_rst_wr", 1'b1, 4'd9, 4'd0, 17'h10222);
    for (int i = 0; i < 50; i++) begin
      drive("rand_post", ($urandom_range(0, 1) != 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), N'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter N, default 17, SHALL set the width of the bus value consumed by this block.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 busin  input  N  SHALL carry the shared bus value driven by the bus multiplexer.
REQ-005 wr_valid  input  1  SHALL qualify write_en; writes occur only when high.
REQ-006 write_en  input  4  SHALL select the write destination: 4=IR, 5=AC, 6=AR, 7=R1, 8=R2, 9=R3, 10=R4, 11=PC, 12=DM; all other codes select no destination.
REQ-007 inc_en  input  4  SHALL request updates: bit0 PC+1, bit1 AC+1, bit2 R1+1, bit3 AC clear.
REQ-008 r1, r2, r3, r4, ir, ac, ar, pc  output  12 each  SHALL present the current register contents.
REQ-009 dm_we  output  1  SHALL strobe a data-memory write.
REQ-010 dm_wdata  output  12  SHALL carry the data-memory write value.
REQ-011 wr_done  output  1  SHALL acknowledge the previous cycle's accepted write.
REQ-012 wr_err  output  1  SHALL flag the previous cycle's qualified write to an unmapped code.

Function
REQ-013 A write SHALL be accepted on a rising clk edge when wr_valid=1; the selected register SHALL take busin[11:0] at that edge.
REQ-014 busin bits N-1:12 SHALL be discarded on every write; no saturation or sign extension.
REQ-015 Registered write data SHALL be visible on outputs in the cycle after acceptance (one-cycle latency).
REQ-016 write_en=12 with wr_valid=1 SHALL set dm_we=1 and dm_wdata=busin[11:0] for exactly the following cycle; no internal register changes.
REQ-017 dm_we SHALL be 0 in every cycle not following a code-12 write; dm_wdata SHALL hold its last value.
REQ-018 wr_done SHALL be a one-cycle pulse in the cycle after any accepted write with a mapped code (4-12).
REQ-019 wr_err SHALL be a one-cycle pulse in the cycle after a qualified write with an unmapped code (0-3, 13-15); no state changes; wr_done stays 0.
REQ-020 inc_en SHALL be sampled every edge, independent of wr_valid.
REQ-021 PC, AC and R1 increments SHALL be modulo 4096 (4095+1 = 0, no carry out).
REQ-022 AC clear (bit3) SHALL take precedence over AC+1 (bit1) in the same cycle.
REQ-023 A write to a register SHALL take precedence over any increment or clear of that register in the same cycle.
REQ-024 Updates to different registers in the same cycle SHALL all take effect (e.g. write R2 and PC+1 together).
REQ-025 Back-to-back writes on consecutive cycles SHALL each be accepted with no stall; wr_done stays high for consecutive accepts.
REQ-026 Registers not addressed by a write or inc_en SHALL hold their value.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force r1-r4, ir, ac, ar, pc, dm_wdata to 0 and dm_we, wr_done, wr_err to 0.
REQ-028 Reset asserted mid-operation SHALL cancel any pending dm_we, wr_done or wr_err pulse.
REQ-029 After rst_n rises, the first edge with wr_valid=1 SHALL be accepted normally.

Verification
REQ-030 Reset: drive state nonzero, pull rst_n low between edges -> all outputs 0 before next edge.
REQ-031 Truncation: busin=17'h1ABCD, write_en=7, wr_valid=1 -> next cycle r1=12'hBCD, wr_done=1 for one cycle.
REQ-032 Wrap: pc=12'hFFF, inc_en=4'b0001 -> pc=12'h000; ac=5, inc_en=4'b1010 -> ac=0.
REQ-033 Priority: ac=3, write_en=5, busin=17'h00010, inc_en=4'b0010 -> ac=12'h010.
REQ-034 DM path: write_en=12, busin=17'h00777 -> next cycle dm_we=1, dm_wdata=12'h777, registers unchanged; following cycle dm_we=0.
REQ-035 Error: write_en=14, wr_valid=1 -> wr_err=1 one cycle, wr_done=0, all registers unchanged.
